// File: rtl/block_mult.sv
// Sequential J x L by L x K half-precision block multiplier.
// One shared fmul/fadd pair performs one multiply-accumulate per cycle.
module block_mult_fmul (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic              s;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [21:0]       p;
    logic [20:0]       pn;
    logic signed [7:0] ex;
    logic              rnd;
    logic [10:0]       mr;

    always_comb begin
        s      = a[15] ^ b[15];
        a_zero = (a[14:10] == 5'h00);
        b_zero = (b[14:10] == 5'h00);
        a_inf  = (a[14:10] == 5'h1f) && (a[9:0] == 10'h0);
        b_inf  = (b[14:10] == 5'h1f) && (b[9:0] == 10'h0);
        a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != 10'h0);
        b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != 10'h0);
        p  = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        ex = $signed({3'b0, a[14:10]}) + $signed({3'b0, b[14:10]}) - 8'sd15;
        if (p[21]) begin
            pn = p[20:0];
            ex = ex + 8'sd1;
        end else begin
            pn = {p[19:0], 1'b0};
        end
        // round to nearest, ties to even
        rnd = pn[10] & ((|pn[9:0]) | pn[11]);
        mr  = {1'b0, pn[20:11]} + 11'(rnd);
        if (mr[10])
            ex = ex + 8'sd1;
        y = {s, ex[4:0], mr[9:0]};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            y = 16'h7e00;
        else if (a_inf || b_inf)
            y = {s, 5'h1f, 10'h0};
        else if (a_zero || b_zero)
            y = {s, 15'h0};
        else if (ex >= 8'sd31)
            y = {s, 5'h1f, 10'h0};
        else if (ex <= 8'sd0)
            y = {s, 15'h0};
    end
endmodule

module block_mult_fadd (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic [15:0]       x, z;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [4:0]        d;
    logic [13:0]       mx, mz, mzs, mask, nrm;
    logic [14:0]       sum;
    logic signed [7:0] ex;
    logic [3:0]        lz;
    logic              rnd;
    logic [10:0]       mr;

    always_comb begin
        a_zero = (a[14:10] == 5'h00);
        b_zero = (b[14:10] == 5'h00);
        a_inf  = (a[14:10] == 5'h1f) && (a[9:0] == 10'h0);
        b_inf  = (b[14:10] == 5'h1f) && (b[9:0] == 10'h0);
        a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != 10'h0);
        b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != 10'h0);
        if (a[14:0] >= b[14:0]) begin
            x = a;
            z = b;
        end else begin
            x = b;
            z = a;
        end
        d    = x[14:10] - z[14:10];
        mx   = {1'b1, x[9:0], 3'b0};
        mz   = {1'b1, z[9:0], 3'b0};
        mask = ~(14'h3fff << d);
        // smaller operand aligned with a sticky bit in the lsb
        if (d >= 5'd14)
            mzs = 14'h0001;
        else
            mzs = (mz >> d) | {13'b0, |(mz & mask)};
        ex = $signed({3'b0, x[14:10]});
        if (x[15] == z[15])
            sum = {1'b0, mx} + {1'b0, mzs};
        else
            sum = {1'b0, mx} - {1'b0, mzs};
        lz = 4'd0;
        if (sum[14]) begin
            nrm = sum[14:1] | {13'b0, sum[0]};
            ex  = ex + 8'sd1;
        end else begin
            for (int i = 0; i < 14; i++)
                if (sum[i])
                    lz = 4'(13 - i);
            nrm = sum[13:0] << lz;
            ex  = ex - $signed({4'b0, lz});
        end
        rnd = nrm[2] & ((|nrm[1:0]) | nrm[3]);
        mr  = {1'b0, nrm[12:3]} + 11'(rnd);
        if (mr[10])
            ex = ex + 8'sd1;
        y = {x[15], ex[4:0], mr[9:0]};
        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15])))
            y = 16'h7e00;
        else if (a_inf)
            y = a;
        else if (b_inf)
            y = b;
        else if (a_zero && b_zero)
            y = {a[15] & b[15], 15'h0};
        else if (a_zero)
            y = b;
        else if (b_zero)
            y = a;
        else if (!nrm[13])
            y = 16'h0000;
        else if (ex >= 8'sd31)
            y = {x[15], 5'h1f, 10'h0};
        else if (ex <= 8'sd0)
            y = {x[15], 15'h0};
    end
endmodule

module block_mult #(
    parameter int DATA_W = 16,
    parameter int J      = 2,
    parameter int K      = 2,
    parameter int L      = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [J*L-1:0][DATA_W-1:0]      block_a,
    input  logic [L*K-1:0][DATA_W-1:0]      block_b,
    output logic [J*K-1:0][DATA_W-1:0]      multiplied_block,
    output logic                            busy,
    output logic                            block_mult_done
);
    localparam int EW = (J * K > 1) ? $clog2(J * K) : 1;
    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam int AW = (J * L > 1) ? $clog2(J * L) : 1;
    localparam int BW = (L * K > 1) ? $clog2(L * K) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

    state_t                       state, state_nx;
    logic [J*L-1:0][DATA_W-1:0]   a_reg;
    logic [L*K-1:0][DATA_W-1:0]   b_reg;
    logic [DATA_W-1:0]            acc, prod, acc_nx, a_op, b_op;
    logic [EW-1:0]                e;
    logic [LW-1:0]                l;
    logic [AW-1:0]                ai;
    logic [BW-1:0]                bi;
    logic                         last_l, last_e;

    assign last_l = (l == LW'(L - 1));
    assign last_e = (e == EW'(J * K - 1));
    // i = e / K, j = e % K
    assign ai   = AW'((32'(e) / K) * L + 32'(l));
    assign bi   = BW'(32'(l) * K + 32'(e) % K);
    assign a_op = a_reg[ai];
    assign b_op = b_reg[bi];
    assign busy = (state == LOAD) || (state == MAC);

    block_mult_fmul u_fmul (.a(a_op), .b(b_op), .y(prod));
    block_mult_fadd u_fadd (.a(acc), .b(prod), .y(acc_nx));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = MAC;
            MAC:     if (last_l && last_e) state_nx = DONE;
            DONE:    if (start) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg            <= '0;
            b_reg            <= '0;
            acc              <= '0;
            e                <= '0;
            l                <= '0;
            multiplied_block <= '0;
            block_mult_done  <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    a_reg           <= block_a;
                    b_reg           <= block_b;
                    acc             <= '0;
                    e               <= '0;
                    l               <= '0;
                    block_mult_done <= 1'b0;
                end
                MAC: begin
                    if (last_l) begin
                        multiplied_block[e] <= acc_nx;
                        acc                 <= '0;
                        l                   <= '0;
                        e                   <= e + EW'(1);
                        if (last_e)
                            block_mult_done <= 1'b1;
                    end else begin
                        acc <= acc_nx;
                        l   <= l + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
